// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller: walks memory_address through the 8 two-byte words of
// a 16-byte block, writing each returned word and the tag on the last word.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] memory_address
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned BASE_W  = ADDR_W - CNT_W - 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(7);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BASE_W-1:0]   base_q;

    // State, word counter and block base; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            base_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_q <= miss_address[ADDR_W-1:CNT_W+1];
                        cnt    <= '0;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (memory_data_valid) begin
                        if (cnt == LAST_WORD) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy and address decode from state only; writes follow valid while filling.
    always_comb begin
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        memory_address   = '0;
        if (state == FILL) begin
            fsm_busy         = 1'b1;
            memory_address   = {base_q, cnt, 1'b0};
            write_data_array = memory_data_valid;
            write_tag_array  = memory_data_valid && (cnt == LAST_WORD);
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm. Observed outputs are packed as
// {fsm_busy, write_data_array, write_tag_array, memory_address} and compared per cycle.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] memory_address;

    int checks;
    int failures;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .memory_address    (memory_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] obs();
        return {fsm_busy, write_data_array, write_tag_array, memory_address};
    endfunction

    // Apply inputs for the current cycle (called just after a rising edge).
    task automatic drive(input logic m, input logic [15:0] a, input logic v);
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
    endtask

    // Move to the next cycle's drive point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        rst = 1'b1;
        drive(1'b0, 16'hBEEF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL reset_hold: got %h required %h", got, 19'h0);
        end
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL reset_idle: got %h required %h", got, 19'h0);
        end
        // Valid in IDLE must be ignored.
        next_cycle();
        drive(1'b0, 16'hBEEF, 1'b1);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL idle_valid_ignored: got %h required %h", got, 19'h0);
        end
        next_cycle();
    endtask

    // Start a fill from IDLE; checks no combinational path from miss to outputs.
    task automatic start_fill(input logic [15:0] a, input string name);
        logic [18:0] got;
        drive(1'b1, a, 1'b0);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL %s_miss_cycle: got %h required %h", name, got, 19'h0);
        end
        next_cycle();
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    // Eight valid pulses, each preceded by three wait cycles.
    task automatic test_slow_fill();
        logic [18:0] got;
        logic [18:0] exp;
        start_fill(16'hDEAD, "slow");
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== {3'b100, 16'hDEA0}) begin
            failures++;
            $display("FAIL slow_first_busy: got %h required %h", got, {3'b100, 16'hDEA0});
        end
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 3; w++) begin
                drive(1'b0, 16'h0000, 1'b0);
                @(negedge clk);
                got = obs();
                exp = {3'b100, 16'hDEA0 + 16'(2 * k)};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL slow_wait_w%0d_c%0d: got %h required %h", k, w, got, exp);
                end
                next_cycle();
            end
            drive(1'b0, 16'h0000, 1'b1);
            @(negedge clk);
            got = obs();
            exp = {1'b1, 1'b1, (k == 7), 16'hDEA0 + 16'(2 * k)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL slow_valid_w%0d: got %h required %h", k, got, exp);
            end
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL slow_done_idle: got %h required %h", got, 19'h0);
        end
        next_cycle();
    endtask

    // Valid held every cycle, then a new miss in the first IDLE cycle after.
    task automatic test_back_to_back();
        logic [18:0] got;
        logic [18:0] exp;
        int data_writes;
        int tag_writes;
        start_fill(16'h5A5F, "b2b");
        data_writes = 0;
        tag_writes  = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            @(negedge clk);
            got = obs();
            exp = {1'b1, 1'b1, (k == 7), 16'h5A50 + 16'(2 * k)};
            data_writes += int'(write_data_array);
            tag_writes  += int'(write_tag_array);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_word%0d: got %h required %h", k, got, exp);
            end
            next_cycle();
        end
        checks++;
        if (data_writes !== 8 || tag_writes !== 1) begin
            failures++;
            $display("FAIL b2b_write_counts: got data=%0d tag=%0d required data=8 tag=1",
                     data_writes, tag_writes);
        end
        start_fill(16'h7777, "b2b_next");
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== {3'b100, 16'h7770}) begin
            failures++;
            $display("FAIL b2b_next_busy: got %h required %h", got, {3'b100, 16'h7770});
        end
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL b2b_next_done: got %h required %h", got, 19'h0);
        end
        next_cycle();
    endtask

    // Reset after three words aborts; a following miss restarts at word 0.
    task automatic test_reset_mid_fill();
        logic [18:0] got;
        logic [18:0] exp;
        start_fill(16'hDEAD, "abort");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL abort_idle: got %h required %h", got, 19'h0);
        end
        next_cycle();
        start_fill(16'h1234, "refill");
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            @(negedge clk);
            got = obs();
            exp = {1'b1, 1'b1, (k == 7), 16'h1230 + 16'(2 * k)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL refill_word%0d: got %h required %h", k, got, exp);
            end
            next_cycle();
        end
    endtask

    // A second miss during a fill must not re-capture the base.
    task automatic test_ignore_miss();
        logic [18:0] got;
        logic [18:0] exp;
        drive(1'b0, 16'h0000, 1'b0);
        next_cycle();
        start_fill(16'hDEAD, "ign");
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            next_cycle();
        end
        drive(1'b1, 16'hF0F0, 1'b0);
        next_cycle();
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== {3'b100, 16'hDEA4}) begin
            failures++;
            $display("FAIL ign_hold: got %h required %h", got, {3'b100, 16'hDEA4});
        end
        next_cycle();
        for (int k = 2; k < 8; k++) begin
            drive((k == 4), 16'h0F0F, 1'b1);
            @(negedge clk);
            got = obs();
            exp = {1'b1, 1'b1, (k == 7), 16'hDEA0 + 16'(2 * k)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ign_word%0d: got %h required %h", k, got, exp);
            end
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== 19'h0) begin
            failures++;
            $display("FAIL ign_done: got %h required %h", got, 19'h0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        test_reset();
        test_slow_fill();
        test_back_to_back();
        test_reset_mid_fill();
        test_ignore_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
